// File: rtl/mem_burst_initiator_pkg.sv
// rtl/mem_burst_initiator_pkg.sv - shared types and constants for the burst initiator
package mem_burst_initiator_pkg;

  typedef enum logic [1:0] {
    MI_IDLE,
    MI_WRITE,
    MI_READ,
    MI_DRAIN
  } mem_init_state_e;

  localparam int MI_RSP_DEPTH = 2;

endpackage

// File: rtl/mem_rsp_fifo.sv
// rtl/mem_rsp_fifo.sv - response FIFO holding {last, data} read beats
module mem_rsp_fifo
  import mem_burst_initiator_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  push,
  input  logic [WIDTH-1:0]                      push_data,
  input  logic                                  pop,
  output logic [WIDTH-1:0]                      head,
  output logic [$clog2(MI_RSP_DEPTH+1)-1:0]     count,
  output logic                                  empty,
  output logic                                  full
);

  localparam int PW = $clog2(MI_RSP_DEPTH);

  logic [WIDTH-1:0] store [MI_RSP_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      store[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = store[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == MI_RSP_DEPTH[$clog2(MI_RSP_DEPTH+1)-1:0]);

endmodule

// File: rtl/mem_burst_initiator.sv
// rtl/mem_burst_initiator.sv - command-driven burst initiator for a single-port synchronous memory
module mem_burst_initiator
  import mem_burst_initiator_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_me,
  output logic                  mem_we,
  output logic                  mem_oe,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(MI_RSP_DEPTH + 1);

  mem_init_state_e        state;
  mem_init_state_e        state_next;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [LEN_WIDTH-1:0]   beats_left;
  logic                   inflight;
  logic                   inflight_last;
  logic                   issue_rd;
  logic                   wr_hs;
  logic                   pop;
  logic                   last_beat;
  logic                   rd_room;
  logic [CW:0]            occupancy;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [DATA_WIDTH:0]    fifo_head;

  assign last_beat = (beats_left == '0);
  assign pop       = rd_valid && rd_ready;
  assign wr_hs     = wr_valid && wr_ready;

  // Count the beat already in flight and credit a same-cycle pop so the
  // two-entry FIFO sustains one beat per cycle without ever overflowing.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign rd_room   = ((occupancy - {{CW{1'b0}}, pop}) < (CW+1)'(MI_RSP_DEPTH))
                     && !(fifo_full && !pop);

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    issue_rd   = 1'b0;
    case (state)
      MI_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = cmd_write ? MI_WRITE : MI_READ;
      end
      MI_WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid && last_beat) state_next = MI_IDLE;
      end
      MI_READ: begin
        issue_rd = rd_room;
        if (rd_room && last_beat) state_next = MI_DRAIN;
      end
      MI_DRAIN: begin
        if (!inflight && fifo_empty) state_next = MI_IDLE;
      end
      default: state_next = MI_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= MI_IDLE;
      addr          <= '0;
      beats_left    <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state         <= state_next;
      inflight      <= issue_rd;
      inflight_last <= issue_rd && last_beat;
      if (cmd_valid && cmd_ready) begin
        addr       <= cmd_addr;
        beats_left <= cmd_len;
      end else if (wr_hs || issue_rd) begin
        addr       <= addr + 1'b1;
        beats_left <= beats_left - 1'b1;
      end
    end
  end

  // Strobes are gated by rst_n so nothing reaches memory during a reset cycle.
  assign mem_me      = rst_n && (wr_hs || issue_rd);
  assign mem_we      = rst_n && wr_hs;
  assign mem_oe      = rst_n && issue_rd;
  assign mem_address = addr;
  assign mem_data    = wr_data;
  assign busy        = (state != MI_IDLE);

  mem_rsp_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data ({inflight_last, mem_rdata}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign rd_valid = !fifo_empty;
  assign rd_data  = rd_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
  assign rd_last  = rd_valid && fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_mem_burst_initiator.sv
// tb/tb_mem_burst_initiator.sv - randomized self-checking bench for mem_burst_initiator
module tb_mem_burst_initiator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready, rd_last, busy;
  logic [7:0] rd_data;
  logic [7:0] mem_address, mem_data, mem_rdata;
  logic       mem_me, mem_we, mem_oe;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_burst_initiator #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy),
    .mem_address(mem_address), .mem_data(mem_data),
    .mem_me(mem_me), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_rdata(mem_rdata)
  );

  // Memory model plus monitor: logs every write strobe and tracks beats issued but not yet popped.
  logic [7:0] tb_mem [256];
  int         cyc = 0;
  int         out_now = 0;
  int         bad_strobe = 0;
  int         rst_strobe = 0;
  logic [7:0] w_addr_q[$];
  logic [7:0] w_data_q[$];
  int         w_cyc_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_me === 1'b1 && mem_we === 1'b1) begin
      tb_mem[mem_address] <= mem_data;
      w_addr_q.push_back(mem_address);
      w_data_q.push_back(mem_data);
      w_cyc_q.push_back(cyc);
      if (!(wr_valid && wr_ready)) bad_strobe <= bad_strobe + 1;
    end
    if (mem_me === 1'b1 && mem_oe === 1'b1 && mem_we === 1'b0) mem_rdata <= tb_mem[mem_address];
    if (rst_n === 1'b0 && (mem_me !== 1'b0 || mem_we !== 1'b0 || mem_oe !== 1'b0))
      rst_strobe <= rst_strobe + 1;
    if (rst_n !== 1'b1) out_now <= 0;
    else out_now <= out_now + ((mem_me && mem_oe && !mem_we) ? 1 : 0)
                            - ((rd_valid && rd_ready) ? 1 : 0);
  end

  // Reference contents of memory as the bench intends them to be after each write burst.
  logic [7:0] ref_mem [256];
  logic [7:0] got_d[$];
  logic       got_l[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [7:0] a, input logic [7:0] l, output bit ok);
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    for (int i = 0; i < 40; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        tick;
        break;
      end
      tick;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic write_beats(input logic [7:0] a, input int n, input int gap_pct,
                             input bit fixed, output bit ok);
    logic [7:0] d;
    logic [7:0] ai;
    bit         acc;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      d  = fixed ? 8'hA0 + 8'(i) : 8'($urandom);
      ai = a + 8'(i);
      ref_mem[ai] = d;
      acc = 1'b0;
      for (int t = 0; t < 50 && !acc; t++) begin
        wr_valid = ($urandom_range(99) >= gap_pct);
        wr_data  = d;
        acc = wr_valid && wr_ready;
        tick;
      end
      if (!acc) ok = 1'b0;
    end
    wr_valid = 1'b0;
  endtask

  task automatic read_beats(input int n, input int mode, output bit ok,
                            output int changed, output int max_out);
    bit         held;
    logic [7:0] hd;
    logic       hl;
    got_d.delete();
    got_l.delete();
    held = 1'b0; changed = 0; max_out = 0; ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = 1'($urandom_range(0, 1));
        default: rd_ready = (k >= 4 && k < 10) ? 1'b0 : (k % 2 == 0);
      endcase
      if (held && (!rd_valid || rd_data !== hd || rd_last !== hl)) changed++;
      if (rd_valid && rd_ready) begin
        got_d.push_back(rd_data);
        got_l.push_back(rd_last);
        held = 1'b0;
      end else if (rd_valid) begin
        held = 1'b1; hd = rd_data; hl = rd_last;
      end else begin
        held = 1'b0;
      end
      tick;
      if (out_now > max_out) max_out = out_now;
      if (got_d.size() == n) begin
        ok = 1'b1;
        break;
      end
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    tick; tick;
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if ({rd_valid, rd_last} !== 2'b00) $display("FAIL reset_rd got %b want 00", {rd_valid, rd_last}); else n_pass++;
    n_checks++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data got %h want 00", rd_data); else n_pass++;
    n_checks++; if (wr_ready !== 1'b0) $display("FAIL reset_wr_ready got %b want 0", wr_ready); else n_pass++;
    n_checks++; if ({mem_me, mem_we, mem_oe} !== 3'b000) $display("FAIL reset_strobes got %b want 000", {mem_me, mem_we, mem_oe}); else n_pass++;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_write_burst;
    bit ok, ok2;
    int s, changed, mx;
    s = w_addr_q.size();
    send_cmd(1'b1, 8'h10, 8'd3, ok);
    write_beats(8'h10, 4, 0, 1'b1, ok2);
    n_checks++; if (!(ok && ok2)) $display("FAIL wb_handshake got %b%b want 11", ok, ok2); else n_pass++;
    n_checks++; if (w_addr_q.size() - s !== 4) $display("FAIL wb_count got %0d want 4", w_addr_q.size() - s); else n_pass++;
    for (int i = 0; i < 4 && s + i < w_addr_q.size(); i++) begin
      n_checks++;
      if (w_addr_q[s+i] !== 8'h10 + 8'(i) || w_data_q[s+i] !== 8'hA0 + 8'(i) || w_cyc_q[s+i] - w_cyc_q[s] !== i)
        $display("FAIL wb_beat%0d got a=%h d=%h dc=%0d want a=%h d=%h dc=%0d", i, w_addr_q[s+i], w_data_q[s+i],
                 w_cyc_q[s+i] - w_cyc_q[s], 8'h10 + 8'(i), 8'hA0 + 8'(i), i);
      else n_pass++;
    end
    n_checks++; if (busy !== 1'b0) $display("FAIL wb_idle got busy=%b want 0", busy); else n_pass++;
    send_cmd(1'b0, 8'h10, 8'd3, ok);
    read_beats(4, 0, ok2, changed, mx);
    n_checks++; if (!(ok && ok2)) $display("FAIL wb_readback_done got %b%b want 11", ok, ok2); else n_pass++;
    for (int i = 0; i < got_d.size(); i++) begin
      n_checks++;
      if (got_d[i] !== 8'hA0 + 8'(i) || got_l[i] !== (i == 3))
        $display("FAIL wb_read%0d got d=%h l=%b want d=%h l=%b", i, got_d[i], got_l[i], 8'hA0 + 8'(i), (i == 3));
      else n_pass++;
    end
  endtask

  task automatic test_read_latency;
    bit ok, ok2;
    logic v0, v1, v2;
    int nvalid;
    logic [7:0] d [8];
    logic       l [8];
    send_cmd(1'b1, 8'h00, 8'd7, ok);
    write_beats(8'h00, 8, 0, 1'b0, ok2);
    rd_ready = 1'b1;
    send_cmd(1'b0, 8'h00, 8'd7, ok);
    v0 = rd_valid; tick;
    v1 = rd_valid; tick;
    v2 = rd_valid;
    n_checks++; if ({v0, v1, v2} !== 3'b001) $display("FAIL lat_first_valid got %b want 001", {v0, v1, v2}); else n_pass++;
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      if (rd_valid) nvalid++;
      d[i] = rd_data; l[i] = rd_last;
      tick;
    end
    n_checks++; if (nvalid !== 8) $display("FAIL lat_consecutive got %0d want 8", nvalid); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (d[i] !== ref_mem[i] || l[i] !== (i == 7))
        $display("FAIL lat_beat%0d got d=%h l=%b want d=%h l=%b", i, d[i], l[i], ref_mem[i], (i == 7));
      else n_pass++;
    end
    n_checks++; if (busy !== 1'b1) $display("FAIL lat_drain_busy got %b want 1", busy); else n_pass++;
    tick;
    n_checks++; if ({busy, cmd_ready} !== 2'b01) $display("FAIL lat_idle got busy,cmd_ready=%b want 01", {busy, cmd_ready}); else n_pass++;
    rd_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    bit ok, ok2;
    int changed, mx;
    logic [7:0] a;
    a = 8'($urandom);
    send_cmd(1'b1, a, 8'd5, ok);
    write_beats(a, 6, 20, 1'b0, ok2);
    send_cmd(1'b0, a, 8'd5, ok);
    read_beats(6, 2, ok2, changed, mx);
    n_checks++; if (!(ok && ok2) || got_d.size() != 6) $display("FAIL bp_beats got %0d want 6", got_d.size()); else n_pass++;
    for (int i = 0; i < got_d.size(); i++) begin
      n_checks++;
      if (got_d[i] !== ref_mem[a + 8'(i)] || got_l[i] !== (i == 5))
        $display("FAIL bp_beat%0d got d=%h l=%b want d=%h l=%b", i, got_d[i], got_l[i], ref_mem[a + 8'(i)], (i == 5));
      else n_pass++;
    end
    n_checks++; if (changed !== 0) $display("FAIL bp_stable got %0d changes want 0", changed); else n_pass++;
    n_checks++; if (mx > 2) $display("FAIL bp_ahead got %0d want <=2", mx); else n_pass++;
  endtask

  task automatic test_wrap;
    bit ok, ok2;
    int s, changed, mx;
    logic [7:0] exp_a [3];
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00;
    s = w_addr_q.size();
    send_cmd(1'b1, 8'hFE, 8'd2, ok);
    write_beats(8'hFE, 3, 0, 1'b0, ok2);
    n_checks++; if (w_addr_q.size() - s !== 3) $display("FAIL wrap_count got %0d want 3", w_addr_q.size() - s); else n_pass++;
    for (int i = 0; i < 3 && s + i < w_addr_q.size(); i++) begin
      n_checks++;
      if (w_addr_q[s+i] !== exp_a[i] || w_data_q[s+i] !== ref_mem[exp_a[i]])
        $display("FAIL wrap_addr%0d got a=%h d=%h want a=%h d=%h", i, w_addr_q[s+i], w_data_q[s+i], exp_a[i], ref_mem[exp_a[i]]);
      else n_pass++;
    end
    send_cmd(1'b0, 8'hFE, 8'd2, ok);
    read_beats(3, 0, ok2, changed, mx);
    n_checks++; if (!(ok && ok2)) $display("FAIL wrap_read_done got %b%b want 11", ok, ok2); else n_pass++;
    for (int i = 0; i < got_d.size(); i++) begin
      n_checks++;
      if (got_d[i] !== ref_mem[exp_a[i]]) $display("FAIL wrap_read%0d got %h want %h", i, got_d[i], ref_mem[exp_a[i]]); else n_pass++;
    end
  endtask

  task automatic test_write_gaps;
    bit ok, ok2;
    int s, bad0;
    logic [7:0] a;
    a = 8'($urandom);
    s = w_addr_q.size();
    bad0 = bad_strobe;
    send_cmd(1'b1, a, 8'd4, ok);
    write_beats(a, 5, 50, 1'b0, ok2);
    tick;
    n_checks++; if (!(ok && ok2) || w_addr_q.size() - s != 5) $display("FAIL gap_count got %0d want 5", w_addr_q.size() - s); else n_pass++;
    for (int i = 0; i < 5 && s + i < w_addr_q.size(); i++) begin
      n_checks++;
      if (w_addr_q[s+i] !== a + 8'(i) || w_data_q[s+i] !== ref_mem[a + 8'(i)])
        $display("FAIL gap_beat%0d got a=%h d=%h want a=%h d=%h", i, w_addr_q[s+i], w_data_q[s+i], a + 8'(i), ref_mem[a + 8'(i)]);
      else n_pass++;
    end
    n_checks++; if (bad_strobe !== bad0) $display("FAIL gap_strobe_no_hs got %0d want %0d", bad_strobe, bad0); else n_pass++;
  endtask

  task automatic test_reset_mid_read;
    bit ok, ok2;
    int changed, mx, rs0;
    send_cmd(1'b1, 8'h40, 8'd2, ok);
    write_beats(8'h40, 3, 0, 1'b0, ok2);
    rd_ready = 1'b0;
    send_cmd(1'b0, 8'h40, 8'd1, ok);
    tick; tick; tick; tick;
    n_checks++; if ({busy, rd_valid, cmd_ready} !== 3'b110) $display("FAIL rst_pre got %b want 110", {busy, rd_valid, cmd_ready}); else n_pass++;
    rs0 = rst_strobe;
    rst_n = 1'b0;
    wr_valid = 1'b1;
    tick;
    n_checks++; if ({rd_valid, cmd_ready, busy} !== 3'b010) $display("FAIL rst_mid_state got %b want 010", {rd_valid, cmd_ready, busy}); else n_pass++;
    n_checks++; if ({mem_me, mem_we, mem_oe} !== 3'b000) $display("FAIL rst_mid_strobes got %b want 000", {mem_me, mem_we, mem_oe}); else n_pass++;
    wr_valid = 1'b0;
    rst_n = 1'b1;
    tick;
    n_checks++; if (rst_strobe !== rs0) $display("FAIL rst_mid_strobe_count got %0d want %0d", rst_strobe, rs0); else n_pass++;
    send_cmd(1'b0, 8'h41, 8'd1, ok);
    read_beats(2, 0, ok2, changed, mx);
    n_checks++; if (!(ok && ok2)) $display("FAIL rst_after_read_done got %b%b want 11", ok, ok2); else n_pass++;
    for (int i = 0; i < got_d.size(); i++) begin
      n_checks++;
      if (got_d[i] !== ref_mem[8'h41 + 8'(i)] || got_l[i] !== (i == 1))
        $display("FAIL rst_after_beat%0d got d=%h l=%b want d=%h l=%b", i, got_d[i], got_l[i], ref_mem[8'h41 + 8'(i)], (i == 1));
      else n_pass++;
    end
  endtask

  task automatic test_random_bursts;
    bit ok, ok2, ok3;
    int changed, mx, n;
    logic [7:0] a, l;
    for (int it = 0; it < 8; it++) begin
      a = 8'($urandom);
      l = 8'($urandom_range(0, 9));
      n = int'(l) + 1;
      send_cmd(1'b1, a, l, ok);
      write_beats(a, n, 30, 1'b0, ok2);
      send_cmd(1'b0, a, l, ok3);
      read_beats(n, 1, ok2, changed, mx);
      n_checks++;
      if (!(ok && ok2 && ok3) || got_d.size() != n || changed != 0 || mx > 2)
        $display("FAIL rand%0d_status got n=%0d chg=%0d ahead=%0d want n=%0d chg=0 ahead<=2", it, got_d.size(), changed, mx, n);
      else n_pass++;
      for (int i = 0; i < got_d.size(); i++) begin
        n_checks++;
        if (got_d[i] !== ref_mem[a + 8'(i)] || got_l[i] !== (i == n - 1))
          $display("FAIL rand%0d_beat%0d got d=%h l=%b want d=%h l=%b", it, i, got_d[i], got_l[i], ref_mem[a + 8'(i)], (i == n - 1));
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_write_burst;
    test_read_latency;
    test_backpressure;
    test_wrap;
    test_write_gaps;
    test_reset_mid_read;
    test_random_bursts;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_burst_initiator.md
# mem_burst_initiator

Burst-capable initiator that drives the single-port synchronous memory interface (address, data, me, we, oe, registered 1-cycle read data). It converts a command stream (start address + beat count, read or write) into per-beat memory strobes. Write data arrives on a valid/ready stream; read data returns on a valid/ready stream with backpressure. It sits between compute/DMA engines and each on-chip memory instance.

## Interface
- DATA_WIDTH, 8, memory word width
- ADDR_WIDTH, 8, memory address width
- LEN_WIDTH, 8, burst length field width; beats = cmd_len + 1
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_WIDTH  first beat address
- cmd_len  in  LEN_WIDTH  beats minus one
- wr_valid  in  1  write beat offered
- wr_ready  out  1  write beat accepted
- wr_data  in  DATA_WIDTH  write beat data
- rd_valid  out  1  read beat available
- rd_ready  in  1  consumer accepts read beat
- rd_data  out  DATA_WIDTH  read beat data
- rd_last  out  1  qualifies final beat of a read burst
- busy  out  1  state != IDLE
- mem_address  out  ADDR_WIDTH  to memory address
- mem_data  out  DATA_WIDTH  to memory write data
- mem_me, mem_we, mem_oe  out  1 each  memory enable / write enable / output enable
- mem_rdata  in  DATA_WIDTH  from memory data out, valid the cycle after a read strobe

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE: cmd_ready = 1. On cmd handshake, latch addr, beat counter = cmd_len, write flag; go to WRITE or READ.
- WRITE: wr_ready = 1. Each wr handshake drives mem_me = mem_we = 1, mem_oe = 0, mem_address = cur addr, mem_data = wr_data in the same cycle, so the memory writes at that edge. Addr increments; on the final beat go to IDLE.
- READ: issue is allowed when (fifo_count − pop + inflight) < 2, where pop = rd_valid && rd_ready. An issue drives mem_me = 1, mem_we = 0, mem_oe = 1. It sets inflight for the next cycle, in which mem_rdata is pushed into the response FIFO with its last flag. After the final issue go to DRAIN.
- DRAIN: no strobes. Go to IDLE when inflight = 0 and the FIFO is empty.
- The address increments modulo 2^ADDR_WIDTH; 0xFF wraps to 0x00 with no error.
- Outside issue cycles, mem_me, mem_we and mem_oe are 0. mem_address and mem_data are don't-care.
- The FIFO never overflows, so memory never needs a stall.
- rd_data, rd_valid and rd_last come from the FIFO head and hold stable while rd_valid && !rd_ready.

## Timing
- Reset (rst_n = 0 at an edge):
  - state = IDLE; FIFO, counter, inflight and addr cleared.
  - Outputs become cmd_ready = 1, busy = 0, rd_valid = 0, rd_last = 0, rd_data = 0, wr_ready = 0, all mem strobes 0.
  - Memory strobes are also gated by rst_n combinationally, so no write is issued during a reset cycle.
  - A reset mid-burst aborts it: pending read beats are discarded and the memory is left with the partial write.
- Write latency: 0. Memory is written at the wr handshake edge. Peak throughput is 1 beat/cycle.
- Read latency: cmd handshake at edge E0, first issue sampled at E1, memory data at E1, FIFO push at E2, rd_valid high after E2. That is 3 cycles from command to first beat.
- Sustained read throughput is 1 beat/cycle with rd_ready held high; the issue condition accounts for the same-cycle pop.
- A new command is not accepted until IDLE, so there is one idle cycle between bursts.
- Simultaneous FIFO push and pop keeps the count unchanged. A pop from an empty FIFO is impossible because pop requires rd_valid.
- cmd_len = 0 is a single beat: in a read, rd_last is asserted on that beat.

## Structure
- DEFINE_PKG gets typedef enum logic [1:0] mem_init_state_e {MI_IDLE, MI_WRITE, MI_READ, MI_DRAIN} and localparam MI_RSP_DEPTH = 2.
- Sub-module mem_rsp_fifo: 2-entry synchronous FIFO of {last, data} with push/pop, count, empty/full, and the same clk/rst_n. It is instantiated once.
- Counters, address register and strobe logic stay in the top module.

## Test plan
- Write burst: addr 0x10, len 3, data A0..A3 with wr_valid held high -> mem_we high on 4 consecutive cycles at 0x10..0x13, then IDLE. A following 4-beat read returns A0..A3 with rd_last on the 4th beat only.
- Read latency and throughput: read addr 0x00, len 7, rd_ready = 1 -> first rd_valid 3 cycles after cmd handshake, then 8 consecutive beats, busy low one cycle after the last.
- Backpressure: read len 5 with rd_ready toggling 1010…, plus a 6-cycle low stretch -> data stays in order, rd_data stable while stalled, issues ≤ 2 ahead of pops, no beat lost or duplicated.
- Wrap: write 3 beats starting at 0xFE -> memory writes at 0xFE, 0xFF, 0x00, and reading them back matches.
- Write gaps: wr_valid gapped randomly over len 4 -> mem_me asserted only on handshake cycles, addresses contiguous.
- Reset mid-read: assert rst_n low during DRAIN with 2 beats buffered -> next cycle rd_valid = 0, cmd_ready = 1, no strobes. A new read command then works normally.
